// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: run-controller state encodings, step counter width and a
// small helper for sizing modulo counters. Shared by cpu_run_ctrl and
// btn_debounce.
package cpu_ctrl_pkg;

  // FSM state encodings (also driven straight onto the state output).
  localparam logic [1:0] ST_HALT = 2'b00;
  localparam logic [1:0] ST_STEP = 2'b01;
  localparam logic [1:0] ST_RUN  = 2'b10;
  localparam logic [1:0] ST_STOP = 2'b11;

  // Width of the executed-instruction counter shown on the display.
  localparam int STEP_CNT_W = 16;

  // Bits needed for a counter that holds 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_btn_debounce.sv
// btn_debounce: two-flop synchronizer, stability counter and rising-edge
// pulse for one raw pushbutton. The accepted level changes only after
// DB_CYCLES consecutive synchronized samples disagree with it; a rising
// change of the accepted level yields a one-cycle registered pulse.
module btn_debounce
  import cpu_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int            CW       = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic          pulse_q,  pulse_d;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive samples that differ from the accepted level; any
  // agreeing sample restarts the count, so glitches never reach the output.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    pulse_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        pulse_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Accepted level, stability counter and edge pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: produces the one-cycle clock enable for the single-cycle
// core. Modes: single step from the step button, free run at one
// instruction every RUN_DIV cycles, stop on a core halt request.
// Optional feature macro: BREAKPOINT_EN (stop RUN when pc hits bp_addr).
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 500000,
  parameter int RUN_DIV   = 25000000,
  parameter int PC_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_step,
  input  logic                  btn_run,
  input  logic                  halt_req,
  input  logic [PC_W-1:0]       pc,
  input  logic [PC_W-1:0]       bp_addr,
  input  logic                  bp_valid,
  output logic                  cpu_en,
  output logic [1:0]            state,
  output logic [STEP_CNT_W-1:0] step_cnt,
  output logic                  bp_hit
);

  localparam int               DIV_W    = cnt_width(RUN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  logic                  step_p;
  logic                  run_p;
  logic                  tick;
  logic                  bp_match;

  logic [1:0]            state_q,  state_d;
  logic                  cpu_en_q, cpu_en_d;
  logic [STEP_CNT_W-1:0] cnt_q,    cnt_d;
  logic [DIV_W-1:0]      div_q,    div_d;
  logic                  bp_hit_q, bp_hit_d;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_db_step (
    .clk_i   (clk),
    .rst_ni  (rst),
    .btn_i   (btn_step),
    .pulse_o (step_p)
  );

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_db_run (
    .clk_i   (clk),
    .rst_ni  (rst),
    .btn_i   (btn_run),
    .pulse_o (run_p)
  );

`ifdef BREAKPOINT_EN
  assign bp_match = bp_valid && (pc == bp_addr);
`else
  // Breakpoint inputs stay on the port list but have no effect here.
  logic unused_bp;
  assign bp_match  = 1'b0;
  assign unused_bp = bp_valid ^ (^pc) ^ (^bp_addr);
`endif

  // Last divider cycle of a RUN period; the enable appears one cycle later.
  assign tick = (state_q == ST_RUN) && (div_q == DIV_LAST);

  // Next-state logic: run_p outranks halt_req, which outranks the breakpoint.
  always_comb begin
    state_d  = state_q;
    cpu_en_d = 1'b0;
    div_d    = '0;
    bp_hit_d = bp_hit_q;
    if (run_p) begin
      bp_hit_d = 1'b0;
    end
    case (state_q)
      ST_HALT: begin
        if (run_p) begin
          state_d = ST_RUN;
        end else if (step_p) begin
          state_d  = ST_STEP;
          cpu_en_d = 1'b1;
        end
      end
      ST_STEP: begin
        state_d = ST_HALT;
      end
      ST_RUN: begin
        if (run_p) begin
          state_d = ST_HALT;
        end else if (halt_req) begin
          state_d = ST_STOP;
        end else if (tick && bp_match) begin
          state_d  = ST_HALT;
          bp_hit_d = 1'b1;
        end else begin
          cpu_en_d = tick;
          div_d    = tick ? '0 : div_q + DIV_W'(1);
        end
      end
      default: begin
        if (run_p || step_p) begin
          state_d = ST_HALT;
        end
      end
    endcase
    cnt_d = cpu_en_d ? cnt_q + STEP_CNT_W'(1) : cnt_q;
  end

  // State, enable, counter, divider and breakpoint flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_HALT;
      cpu_en_q <= 1'b0;
      cnt_q    <= '0;
      div_q    <= '0;
      bp_hit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cpu_en_q <= cpu_en_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      bp_hit_q <= bp_hit_d;
    end
  end

  assign cpu_en   = cpu_en_q;
  assign state    = state_q;
  assign step_cnt = cnt_q;
  assign bp_hit   = bp_hit_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed stimulus for cpu_run_ctrl with DB_CYCLES=4 and
// RUN_DIV=5, a behavioural reference compared on every falling clock edge,
// and literal expectations at key points of each scenario.
module tb_cpu_run_ctrl;

  localparam int DB   = 4;
  localparam int RDIV = 5;
  localparam int PW   = 32;

  localparam logic [1:0] S_HALT = 2'b00;
  localparam logic [1:0] S_STEP = 2'b01;
  localparam logic [1:0] S_RUN  = 2'b10;
  localparam logic [1:0] S_STOP = 2'b11;

`ifdef BREAKPOINT_EN
  localparam bit BP_ON = 1'b1;
`else
  localparam bit BP_ON = 1'b0;
`endif

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          btn_step = 1'b0;
  logic          btn_run  = 1'b0;
  logic          halt_req = 1'b0;
  logic          bp_valid = 1'b0;
  logic [PW-1:0] pc       = '0;
  logic [PW-1:0] bp_addr  = '0;
  logic          cpu_en;
  logic [1:0]    state;
  logic [15:0]   step_cnt;
  logic          bp_hit;

  int checks  = 0;
  int errors  = 0;
  int en_seen = 0;
  int base    = 0;

  cpu_run_ctrl #(
    .DB_CYCLES (DB),
    .RUN_DIV   (RDIV),
    .PC_W      (PW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_step (btn_step),
    .btn_run  (btn_run),
    .halt_req (halt_req),
    .pc       (pc),
    .bp_addr  (bp_addr),
    .bp_valid (bp_valid),
    .cpu_en   (cpu_en),
    .state    (state),
    .step_cnt (step_cnt),
    .bp_hit   (bp_hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  // Buttons: raw sample history; a level is accepted once the DB samples
  // seen by the counter (two cycles of synchronizer latency) all disagree.
  // RUN: m_age counts cycles spent in RUN; every RDIV-th one is a tick.
  logic [1:0]    m_state;
  bit            m_en;
  bit [15:0]     m_cnt;
  bit            m_bp;
  int            m_age;
  bit            m_step_p, m_run_p, m_lvl_s, m_lvl_r;
  bit [DB+1:0]   m_ws, m_wr;

  task automatic m_reset();
    m_state  = S_HALT;
    m_en     = 1'b0;
    m_cnt    = 16'd0;
    m_bp     = 1'b0;
    m_age    = 0;
    m_step_p = 1'b0;
    m_run_p  = 1'b0;
    m_lvl_s  = 1'b0;
    m_lvl_r  = 1'b0;
    m_ws     = '0;
    m_wr     = '0;
  endtask

  task automatic m_edge();
    bit fire;
    bit tick;
    bit hit;
    fire = 1'b0;
    if (m_run_p) m_bp = 1'b0;
    case (m_state)
      S_HALT: begin
        if (m_run_p) begin
          m_state = S_RUN;
          m_age   = 0;
        end else if (m_step_p) begin
          m_state = S_STEP;
          fire    = 1'b1;
        end
      end
      S_STEP: m_state = S_HALT;
      S_RUN: begin
        tick = ((m_age % RDIV) == RDIV - 1);
        hit  = BP_ON && bp_valid && (pc == bp_addr);
        if (m_run_p) m_state = S_HALT;
        else if (halt_req) m_state = S_STOP;
        else if (tick && hit) begin
          m_state = S_HALT;
          m_bp    = 1'b1;
        end else begin
          fire  = tick;
          m_age = m_age + 1;
        end
      end
      default: if (m_run_p || m_step_p) m_state = S_HALT;
    endcase
    m_en = fire;
    if (fire) m_cnt = m_cnt + 16'd1;
    m_ws     = {m_ws[DB:0], btn_step};
    m_wr     = {m_wr[DB:0], btn_run};
    m_step_p = 1'b0;
    m_run_p  = 1'b0;
    if (m_ws[DB+1:2] == {DB{~m_lvl_s}}) begin
      m_lvl_s  = ~m_lvl_s;
      m_step_p = m_lvl_s;
    end
    if (m_wr[DB+1:2] == {DB{~m_lvl_r}}) begin
      m_lvl_r = ~m_lvl_r;
      m_run_p = m_lvl_r;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) m_reset();
      else m_edge();
    end
  end

  // Per-cycle comparison against the reference, plus enable pulse count.
  initial begin
    forever begin
      @(negedge clk);
      if (cpu_en === 1'b1) en_seen++;
      check("cmp_state", 32'(state), 32'(m_state));
      check("cmp_cpu_en", 32'(cpu_en), 32'(m_en));
      check("cmp_step_cnt", 32'(step_cnt), 32'(m_cnt));
      check("cmp_bp_hit", 32'(bp_hit), 32'(m_bp));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    #1 rst = 1'b0;
    #1;
    check("reset_state", 32'(state), 32'(2'b00));
    check("reset_cpu_en", 32'(cpu_en), 32'd0);
    check("reset_step_cnt", 32'(step_cnt), 32'd0);
    check("reset_bp_hit", 32'(bp_hit), 32'd0);
    ticks(3);
    rst = 1'b1;
    ticks(2);

    // Glitches then a long step press: one pulse.
    base = en_seen;
    repeat (2) begin
      btn_step = 1'b1; ticks(1);
      btn_step = 1'b0; ticks(2);
    end
    btn_step = 1'b1; ticks(10);
    btn_step = 1'b0; ticks(25);
    check("step_pulses", 32'(en_seen - base), 32'd1);
    check("step_cnt_after_step", 32'(step_cnt), 32'd1);
    check("state_after_step", 32'(state), 32'(2'b00));

    // Three-cycle press is too short.
    base = en_seen;
    btn_step = 1'b1; ticks(3);
    btn_step = 1'b0; ticks(15);
    check("short_press_pulses", 32'(en_seen - base), 32'd0);
    check("short_press_cnt", 32'(step_cnt), 32'd1);

    // Both buttons together from HALT: run wins.
    btn_step = 1'b1; btn_run = 1'b1; ticks(6);
    btn_step = 1'b0; btn_run = 1'b0; ticks(1);
    check("both_state", 32'(state), 32'(2'b10));
    check("both_no_step_cnt", 32'(step_cnt), 32'd1);
    ticks(1);
    check("both_no_step_en", 32'(cpu_en), 32'd0);
    ticks(13);
    check("run_cnt_before_halt", 32'(step_cnt), 32'd3);
    halt_req = 1'b1; ticks(1);
    check("halt_state", 32'(state), 32'(2'b11));
    check("halt_no_en", 32'(cpu_en), 32'd0);
    check("halt_cnt", 32'(step_cnt), 32'd3);
    halt_req = 1'b0;
    btn_step = 1'b1; ticks(6);
    btn_step = 1'b0; ticks(1);
    check("stop_step_state", 32'(state), 32'(2'b00));
    ticks(10);
    check("stop_step_state_hold", 32'(state), 32'(2'b00));
    check("stop_step_cnt", 32'(step_cnt), 32'd3);

    // Reset in the middle of RUN.
    btn_run = 1'b1; ticks(6);
    btn_run = 1'b0; ticks(3);
    check("pre_reset_state", 32'(state), 32'(2'b10));
    rst = 1'b0;
    #1;
    check("midrun_rst_state", 32'(state), 32'(2'b00));
    check("midrun_rst_en", 32'(cpu_en), 32'd0);
    check("midrun_rst_cnt", 32'(step_cnt), 32'd0);
    check("midrun_rst_bp", 32'(bp_hit), 32'd0);
    ticks(2);
    rst = 1'b1;
    ticks(2);

    // Free run: pulse every 5th cycle, then stop with a second press.
    btn_run = 1'b1; ticks(6);
    btn_run = 1'b0; ticks(25);
    check("run_en_gap", 32'(cpu_en), 32'd0);
    check("run_cnt_4", 32'(step_cnt), 32'd4);
    ticks(1);
    check("run_en_5", 32'(cpu_en), 32'd1);
    check("run_cnt_5", 32'(step_cnt), 32'd5);
    check("run_state", 32'(state), 32'(2'b10));
    btn_run = 1'b1; ticks(6);
    btn_run = 1'b0; ticks(1);
    check("run_stop_state", 32'(state), 32'(2'b00));
    check("run_stop_cnt", 32'(step_cnt), 32'd6);
    base = en_seen;
    ticks(20);
    check("run_stop_no_pulse", 32'(en_seen - base), 32'd0);

    // Breakpoint at 0x10 (only takes effect with the feature built in).
    bp_addr = 32'h10; pc = 32'h10; bp_valid = 1'b1;
    btn_run = 1'b1; ticks(6);
    btn_run = 1'b0; ticks(6);
`ifdef BREAKPOINT_EN
    check("bp_state", 32'(state), 32'(2'b00));
    check("bp_hit_set", 32'(bp_hit), 32'd1);
    check("bp_no_en", 32'(cpu_en), 32'd0);
    check("bp_cnt", 32'(step_cnt), 32'd6);
`else
    check("nobp_state", 32'(state), 32'(2'b10));
    check("nobp_hit", 32'(bp_hit), 32'd0);
    check("nobp_en", 32'(cpu_en), 32'd1);
    check("nobp_cnt", 32'(step_cnt), 32'd7);
`endif
    btn_run = 1'b1; ticks(6);
    btn_run = 1'b0; ticks(1);
`ifdef BREAKPOINT_EN
    check("bp_cleared", 32'(bp_hit), 32'd0);
    check("bp_rerun_state", 32'(state), 32'(2'b10));
`else
    check("nobp_halt_state", 32'(state), 32'(2'b00));
    check("nobp_halt_cnt", 32'(step_cnt), 32'd8);
`endif
    ticks(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
